// File: rtl/snn_pkg.sv
// snn_pkg: QS2.13 constants, saturation helper and layer FSM states shared by the SNN blocks
package snn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS = 13;
  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = 16'sh7FFF;
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = 16'sh8000;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  // the top three bits agree exactly when the wide sum fits in DATA_WIDTH
  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH+1:0] x);
    return (x[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000 || x[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111)
      ? x[DATA_WIDTH-1:0] : (x[DATA_WIDTH+1] ? MIN_VAL : MAX_VAL);
  endfunction
endpackage

// File: rtl/lif_update.sv
// lif_update: combinational leak, integrate, saturate and subtract-reset for one neuron
module lif_update
  import snn_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0] v,
  input  logic signed [DATA_WIDTH-1:0] current,
  input  logic signed [DATA_WIDTH-1:0] beta,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic signed [DATA_WIDTH-1:0] v_next,
  output logic                         fire
);
  logic signed [2*DATA_WIDTH-1:0] prod, decay;
  logic signed [DATA_WIDTH+1:0] sum;
  logic signed [DATA_WIDTH-1:0] sat;
  always_comb begin
    prod = (2*DATA_WIDTH)'(beta) * (2*DATA_WIDTH)'(v);
    decay = prod >>> FRAC_BITS;
    sum = decay[DATA_WIDTH+1:0] + {{2{current[DATA_WIDTH-1]}}, current};
    sat = saturate(sum);
    fire = sat >= threshold;
    v_next = fire ? sat - threshold : sat;
  end
endmodule

// File: rtl/lif_neuron_layer.sv
// lif_neuron_layer: per-neuron LIF membranes fed by a serial current stream, emitting one spike vector per timestep
module lif_neuron_layer #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 13,
  parameter logic signed [DATA_WIDTH-1:0] BETA = 16'sh1CCD,
  parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = 16'sh2000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic signed [DATA_WIDTH-1:0]   in_current,
  input  logic [$clog2(NUM_NEURONS)-1:0] in_idx,
  input  logic                           in_valid,
  input  logic                           in_done,
  output logic [NUM_NEURONS-1:0]         spike_vec,
  output logic                           spikes_valid,
  output logic                           busy,
  output logic                           idx_err,
  input  logic [$clog2(NUM_NEURONS)-1:0] mem_rd_idx,
  output logic signed [DATA_WIDTH-1:0]   mem_rd_data
);
  logic signed [DATA_WIDTH-1:0] v [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] v_next;
  logic [NUM_NEURONS-1:0] pend, pend_next;
  logic fire, in_range, accept, done;
  snn_pkg::state_t state, state_next;
  lif_update u_upd (
    .v(v[in_idx]),
    .current(in_current),
    .beta(BETA),
    .threshold(THRESHOLD),
    .v_next(v_next),
    .fire(fire)
  );
  assign in_range = 32'(in_idx) < NUM_NEURONS;
  assign accept = in_valid && in_range && !clear;
  assign done = in_valid && in_done && !clear;
  assign busy = state == snn_pkg::COLLECT;
  assign spikes_valid = state == snn_pkg::EMIT;
  always_comb begin
    pend_next = pend;
    if (accept) pend_next[in_idx] = pend[in_idx] | fire;
    state_next = in_valid ? (in_done ? snn_pkg::EMIT : snn_pkg::COLLECT)
               : (state == snn_pkg::EMIT ? snn_pkg::IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_NEURONS; i++) v[i] <= '0;
      pend <= '0;
      state <= snn_pkg::IDLE;
      mem_rd_data <= '0;
    end else begin
      state <= state_next;
      if (accept) v[in_idx] <= v_next;
      pend <= done ? '0 : pend_next;
      mem_rd_data <= (accept && in_idx == mem_rd_idx) ? v_next : v[mem_rd_idx];
    end
    if (reset) begin
      spike_vec <= '0;
      idx_err <= 1'b0;
    end else if (!clear) begin
      if (done) spike_vec <= pend_next;
      if (in_valid && !in_range) idx_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lif_neuron_layer.sv
// tb_lif_neuron_layer: directed checks of the LIF layer against hand-computed QS2.13 values
module tb_lif_neuron_layer;
  logic clk = 0, reset = 1, clear = 0, in_valid = 0, in_done = 0;
  logic [15:0] in_current = 0;
  logic [3:0] in_idx = 0, mem_rd_idx = 0;
  logic [15:0] spike_vec, mem_rd_data;
  logic spikes_valid, busy, idx_err;
  logic clr12 = 0, v12 = 0, d12 = 0;
  logic [15:0] c12 = 0;
  logic [3:0] i12 = 0, rd12 = 0;
  logic [11:0] sv12;
  logic [15:0] md12;
  logic svv12, busy12, err12;
  logic [15:0] u_v_next;
  logic u_fire;
  int checks = 0, errors = 0, busy_cnt;

  always #5 clk = ~clk;

  lif_neuron_layer dut (
    .clk(clk), .reset(reset), .clear(clear), .in_current(in_current), .in_idx(in_idx),
    .in_valid(in_valid), .in_done(in_done), .spike_vec(spike_vec), .spikes_valid(spikes_valid),
    .busy(busy), .idx_err(idx_err), .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data)
  );

  lif_neuron_layer #(.NUM_NEURONS(12)) dut12 (
    .clk(clk), .reset(reset), .clear(clr12), .in_current(c12), .in_idx(i12),
    .in_valid(v12), .in_done(d12), .spike_vec(sv12), .spikes_valid(svv12),
    .busy(busy12), .idx_err(err12), .mem_rd_idx(rd12), .mem_rd_data(md12)
  );

  lif_update u_unit (
    .v(16'sh7000), .current(16'sh7FFF), .beta(16'sh1CCD), .threshold(16'sh2000),
    .v_next(u_v_next), .fire(u_fire)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] idx, input logic [15:0] cur, input logic dn);
    in_valid = 1; in_idx = idx; in_current = cur; in_done = dn;
    tick();
    in_valid = 0; in_done = 0;
  endtask

  task automatic rd(input logic [3:0] idx);
    mem_rd_idx = idx;
    tick();
  endtask

  task automatic stream(input string tag);
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_idx = 4'(i); in_current = i[0] ? 16'h2000 : 16'h0000; in_done = (i == 15);
      tick();
      if (busy) busy_cnt++;
    end
    in_valid = 0; in_done = 0;
    chk({tag, "_spike_vec"}, 32'(spike_vec), 32'hAAAA);
    chk({tag, "_spikes_valid"}, 32'(spikes_valid), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd15);
    tick();
    chk({tag, "_spikes_valid_drop"}, 32'(spikes_valid), 32'd0);
    rd(4'd1);
    chk({tag, "_v1_after_fire"}, 32'(mem_rd_data), 32'h0000);
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    chk("rst_spike_vec", 32'(spike_vec), 32'h0);
    chk("rst_spikes_valid", 32'(spikes_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_idx_err", 32'(idx_err), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd_data), 32'h0);
    chk("unit_sat_v", 32'(u_v_next), 32'h5FFF);
    chk("unit_sat_fire", 32'(u_fire), 32'h1);

    send(4'd0, 16'h1000, 1);
    chk("ts1_valid", 32'(spikes_valid), 32'h1);
    chk("ts1_spikes", 32'(spike_vec), 32'h0);
    rd(4'd0);
    chk("ts1_v0", 32'(mem_rd_data), 32'h1000);
    send(4'd0, 16'h1000, 1);
    chk("ts2_spikes", 32'(spike_vec), 32'h0);
    rd(4'd0);
    chk("ts2_v0", 32'(mem_rd_data), 32'h1E66);
    send(4'd0, 16'h1000, 1);
    chk("ts3_valid", 32'(spikes_valid), 32'h1);
    chk("ts3_spikes", 32'(spike_vec), 32'h0001);
    rd(4'd0);
    chk("ts3_v0", 32'(mem_rd_data), 32'h0B5B);

    clear = 1;
    send(4'd2, 16'h7FFF, 1);
    clear = 0;
    chk("clr_spike_vec_kept", 32'(spike_vec), 32'h0001);
    chk("clr_no_emit", 32'(spikes_valid), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    rd(4'd2);
    chk("clr_v2", 32'(mem_rd_data), 32'h0);
    rd(4'd0);
    chk("clr_v0", 32'(mem_rd_data), 32'h0);

    stream("stream1");

    send(4'd3, 16'h7FFF, 1);
    send(4'd3, 16'h7FFF, 1);
    chk("sat_spikes", 32'(spike_vec), 32'h0008);
    rd(4'd3);
    chk("sat_v3", 32'(mem_rd_data), 32'h5FFF);

    send(4'd4, 16'h8000, 1);
    chk("neg_spikes", 32'(spike_vec), 32'h0);
    rd(4'd4);
    chk("neg_v4", 32'(mem_rd_data), 32'h8000);
    send(4'd4, 16'h0000, 1);
    rd(4'd4);
    chk("neg_floor_v4", 32'(mem_rd_data), 32'h8CCC);

    send(4'd5, 16'h1000, 0);
    chk("b2b_busy", 32'(busy), 32'h1);
    send(4'd5, 16'h1000, 1);
    rd(4'd5);
    chk("b2b_v5", 32'(mem_rd_data), 32'h1E66);

    mem_rd_idx = 4'd6;
    send(4'd6, 16'h0100, 1);
    chk("rd_forward_v6", 32'(mem_rd_data), 32'h0100);

    v12 = 1; i12 = 4'd5; c12 = 16'h1000; d12 = 0; rd12 = 4'd5;
    tick();
    i12 = 4'd13; d12 = 1;
    tick();
    v12 = 0; d12 = 0;
    chk("oor_idx_err", 32'(err12), 32'h1);
    chk("oor_done_emits", 32'(svv12), 32'h1);
    tick();
    chk("oor_v5_kept", 32'(md12), 32'h1000);
    rd12 = 4'd1;
    tick();
    chk("oor_v1_kept", 32'(md12), 32'h0);
    clr12 = 1;
    tick();
    clr12 = 0;
    tick(); tick();
    chk("oor_err_sticky", 32'(err12), 32'h1);

    for (int i = 0; i < 5; i++) send(4'(i), 16'h3000, 0);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_spike_vec", 32'(spike_vec), 32'h0);
    chk("mid_rst_valid", 32'(spikes_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_idx_err", 32'(idx_err), 32'h0);
    chk("mid_rst_mem_rd", 32'(mem_rd_data), 32'h0);
    chk("rst_clears_err12", 32'(err12), 32'h0);
    rd(4'd0);
    chk("mid_rst_v0", 32'(mem_rd_data), 32'h0);
    stream("stream2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
